// File: rtl/switch_bounce_gen.sv
// Mechanical-switch emulator: turns a clean level command into a burst of
// pseudo-random-width contact glitches followed by a held final level.
`timescale 1ns/1ps
module switch_bounce_gen #(
  parameter int          NUM_BOUNCE = 3,
  parameter int          MIN_GAP    = 4,
  parameter int          GAP_W      = 4,
  parameter int          SETTLE_CYC = 16,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic cmd,
  output logic sw_out,
  output logic busy,
  output logic done
);

  localparam int GAP_MAX = MIN_GAP + 255;
  localparam int CNT_MAX = (GAP_MAX > SETTLE_CYC) ? GAP_MAX : SETTLE_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int TOG_N   = 2 * NUM_BOUNCE - 1;
  localparam int TOG_W   = $clog2(TOG_N + 1);
  // A zero-width gap field collapses to an all-zero mask, so every gap is MIN_GAP.
  localparam logic [15:0] GAP_MASK = 16'((32'd1 << GAP_W) - 32'd1);

  typedef enum logic [1:0] {IDLE, BOUNCE, SETTLE} state_t;

  state_t           state;
  logic [15:0]      lfsr;
  logic [CNT_W-1:0] cnt;
  logic [TOG_W-1:0] tog;

  // Fibonacci LFSR, x^16 + x^14 + x^13 + x^11 + 1.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic logic [CNT_W-1:0] gap_of(input logic [15:0] s);
    logic [15:0] r;
    r = s & GAP_MASK;
    return CNT_W'(MIN_GAP) + CNT_W'(r);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr <= LFSR_SEED;
    else       lfsr <= lfsr_next(lfsr);
  end

  // A counter loaded with N reaches 1 on the N-th edge after the load; that edge is the expiry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      sw_out <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      cnt    <= '0;
      tog    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (!en) begin
            sw_out <= cmd;
          end else if (cmd != sw_out) begin
            state <= BOUNCE;
            cnt   <= gap_of(lfsr);
            tog   <= '0;
            busy  <= 1'b1;
          end
        end
        BOUNCE: begin
          if (cnt == CNT_W'(1)) begin
            sw_out <= ~sw_out;
            tog    <= tog + 1'b1;
            if (tog == TOG_W'(TOG_N - 1)) begin
              state <= SETTLE;
              cnt   <= CNT_W'(SETTLE_CYC);
            end else begin
              cnt <= gap_of(lfsr);
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        SETTLE: begin
          if (cnt == CNT_W'(1)) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_switch_bounce_gen.sv
// Directed bench: a fixed-gap instance for exact timing and a random-gap
// instance checked against a reference LFSR.
`timescale 1ns/1ps
module tb_switch_bounce_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] en, cmd;
  logic       a_sw, a_busy, a_done;
  logic       b_sw, b_busy, b_done;

  always #5 clk = ~clk;

  switch_bounce_gen #(
    .NUM_BOUNCE(3), .MIN_GAP(4), .GAP_W(0), .SETTLE_CYC(10), .LFSR_SEED(16'hACE1)
  ) u_det (
    .clk(clk), .reset(reset), .en(en[0]), .cmd(cmd[0]),
    .sw_out(a_sw), .busy(a_busy), .done(a_done)
  );

  switch_bounce_gen #(
    .NUM_BOUNCE(3), .MIN_GAP(4), .GAP_W(4), .SETTLE_CYC(16), .LFSR_SEED(16'hACE1)
  ) u_rnd (
    .clk(clk), .reset(reset), .en(en[1]), .cmd(cmd[1]),
    .sw_out(b_sw), .busy(b_busy), .done(b_done)
  );

  // Reference LFSR; m_prev holds the value the DUT saw at the most recent edge.
  logic [15:0] m, m_prev;

  function automatic logic [15:0] ref_next(input logic [15:0] s);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return {s[14:0], fb};
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m      <= 16'hACE1;
      m_prev <= 16'hACE1;
    end else begin
      m_prev <= m;
      m      <= ref_next(m);
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic get_sw(input int d);
    return (d == 1) ? b_sw : a_sw;
  endfunction
  function automatic logic get_busy(input int d);
    return (d == 1) ? b_busy : a_busy;
  endfunction
  function automatic logic get_done(input int d);
    return (d == 1) ? b_done : a_done;
  endfunction

  int tog_t[16];
  int exp_g[16];
  int ntog, done_t, busy_n;

  // t counts negedges after the event's start edge; t=0 follows the start edge.
  task automatic watch(input int d, input int budget, input int chg_t, input logic chg_v);
    logic prev;
    ntog = 0; done_t = -1; busy_n = 0;
    for (int k = 0; k < 16; k++) begin
      tog_t[k] = -1;
      exp_g[k] = -1;
    end
    prev = get_sw(d);
    for (int t = 0; t < budget; t++) begin
      @(negedge clk);
      if (t == chg_t) cmd[d] = chg_v;
      if (t == 0) exp_g[0] = 4 + int'(m_prev[3:0]);
      if (get_busy(d)) busy_n++;
      if (get_sw(d) != prev) begin
        if (ntog < 15) begin
          tog_t[ntog] = t;
          ntog++;
          exp_g[ntog] = 4 + int'(m_prev[3:0]);
        end
        prev = get_sw(d);
      end
      if (get_done(d)) begin
        done_t = t;
        break;
      end
    end
    check($sformatf("done_seen_d%0d", d), int'(done_t >= 0), 1);
  endtask

  task automatic check_det(input string pfx, input int final_v);
    check({pfx, "_ntog"}, ntog, 5);
    for (int k = 0; k < 5; k++)
      check($sformatf("%s_tog%0d", pfx, k), tog_t[k], 4 * (k + 1));
    check({pfx, "_done_t"}, done_t, 30);
    check({pfx, "_busy_cycles"}, busy_n, 30);
    check({pfx, "_final_sw"}, int'(a_sw), final_v);
    check({pfx, "_busy_low_at_done"}, int'(a_busy), 0);
  endtask

  task automatic check_rnd(input string pfx, input int final_v);
    int iv;
    check({pfx, "_ntog"}, ntog, 5);
    for (int k = 0; k < 5; k++) begin
      iv = tog_t[k] - ((k == 0) ? 0 : tog_t[k-1]);
      check($sformatf("%s_iv%0d_range", pfx, k), int'(iv >= 4 && iv <= 19), 1);
      check($sformatf("%s_iv%0d_model", pfx, k), iv, exp_g[k]);
    end
    check({pfx, "_settle"}, done_t - tog_t[4], 16);
    check({pfx, "_busy_cycles"}, busy_n, done_t);
    check({pfx, "_final_sw"}, int'(b_sw), final_v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    int nd, nb;
    reset = 1'b1; en = 2'b00; cmd = 2'b00;
    repeat (3) @(negedge clk);
    check("rst_sw", int'(a_sw), 0);
    check("rst_busy", int'(a_busy), 0);
    check("rst_done", int'(a_done), 0);
    reset = 1'b0;

    // Bypass drives sw_out high, then an asynchronous reset pulls it low mid-cycle.
    @(negedge clk);
    cmd[0] = 1'b1;
    check("byp0_before_edge", int'(a_sw), 0);
    @(negedge clk);
    check("byp0_after_edge", int'(a_sw), 1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_rst_sw", int'(a_sw), 0);
    check("async_rst_busy", int'(a_busy), 0);
    check("async_rst_done", int'(a_done), 0);
    cmd[0] = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Fixed-gap event 0 -> 1.
    @(negedge clk);
    en[0] = 1'b1; cmd[0] = 1'b1;
    watch(0, 100, -1, 1'b0);
    check_det("ev1", 1);
    @(negedge clk);
    check("ev1_done_one_cycle", int'(a_done), 0);
    check("ev1_idle_busy", int'(a_busy), 0);

    // Fixed-gap event 1 -> 0.
    cmd[0] = 1'b0;
    watch(0, 100, -1, 1'b0);
    check_det("ev2", 0);

    // cmd drops back mid-bounce: event still lands at 1, then a new one starts right away.
    @(negedge clk);
    cmd[0] = 1'b1;
    watch(0, 100, 6, 1'b0);
    check_det("mid", 1);
    watch(0, 100, -1, 1'b0);
    check_det("mid_restart", 0);

    // Bypass pattern 1,0,1 with one-cycle latency.
    @(negedge clk);
    en[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      logic v, old;
      v = (i != 1);
      old = a_sw;
      cmd[0] = v;
      check($sformatf("byp%0d_hold", i), int'(a_sw), int'(old));
      @(negedge clk);
      check($sformatf("byp%0d_sw", i), int'(a_sw), int'(v));
      check($sformatf("byp%0d_busy", i), int'(a_busy), 0);
      check($sformatf("byp%0d_done", i), int'(a_done), 0);
    end

    // Reset mid-event abandons the event without a done pulse.
    en[0] = 1'b1; cmd[0] = 1'b0;
    repeat (9) @(negedge clk);
    check("rstmid_busy_pre", int'(a_busy), 1);
    check("rstmid_sw_pre", int'(a_sw), 1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("rstmid_sw", int'(a_sw), 0);
    check("rstmid_busy", int'(a_busy), 0);
    check("rstmid_done", int'(a_done), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    nd = 0; nb = 0;
    repeat (40) begin
      @(negedge clk);
      if (a_done) nd++;
      if (a_busy) nb++;
    end
    check("rstmid_no_done", nd, 0);
    check("rstmid_no_busy", nb, 0);

    // Random-gap events against the reference LFSR.
    @(negedge clk);
    en[1] = 1'b1; cmd[1] = 1'b1;
    watch(1, 1000, -1, 1'b0);
    check_rnd("rnd1", 1);
    @(negedge clk);
    cmd[1] = 1'b0;
    watch(1, 1000, -1, 1'b0);
    check_rnd("rnd2", 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
